led_fade_driver: RTL and testbench

- Downstream consumer of the 8-bit LED PIO output port.
- Converts each per-LED on/off request bit into a PWM-driven LED output with a linear brightness fade-in and fade-out.
- Sits between the Avalon PIO out_port and the board LED pins. No bus interface; it is a pure datapath stage.

---
 rtl/led_fade_pkg.sv | 57 +++++
 rtl/led_fade_channel.sv | 108 ++++++++++
 rtl/led_fade_driver.sv | 84 ++++++++
 tb/tb_led_fade_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// -----------------------------------------------------------------------------
// led_fade_pkg
// Shared types, constants and saturating helpers for the LED fade driver.
//
// Optional build macro: LED_FADE_GAMMA_EN
//   When defined, the gamma() helper is compiled in for the perceptual duty map.
//
// The helpers work at a fixed 16-bit calculation width with one extra carry or
// borrow bit. This lets every channel width up to 16 bits share them. Callers
// zero-extend their level into calc_t and truncate the result back.
// -----------------------------------------------------------------------------
package led_fade_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam logic [PWM_BITS_DEF-1:0] PWM_MAX = {PWM_BITS_DEF{1'b1}};

  typedef logic [PWM_BITS_DEF-1:0] pwm_level_t;

  localparam int CALC_W = 16;
  typedef logic [CALC_W-1:0] calc_t;

  // Add with the carry kept, then clamp to max_v so the level never wraps.
  function automatic calc_t sat_add(input calc_t a, input calc_t step, input calc_t max_v);
    logic [CALC_W:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, step};
    if (sum_s > {1'b0, max_v}) begin
      return max_v;
    end else begin
      return sum_s[CALC_W-1:0];
    end
  endfunction

  // Subtract with the borrow kept; a borrow means the result clamps to zero.
  function automatic calc_t sat_sub(input calc_t a, input calc_t step);
    logic [CALC_W:0] diff_s;
    diff_s = {1'b0, a} - {1'b0, step};
    if (diff_s[CALC_W]) begin
      return {CALC_W{1'b0}};
    end else begin
      return diff_s[CALC_W-1:0];
    end
  endfunction

`ifdef LED_FADE_GAMMA_EN
  // Square-law map. Full scale is pinned to max_v so that fully on stays fully on.
  function automatic calc_t gamma(input calc_t lvl, input calc_t max_v, input int bits);
    logic [2*CALC_W-1:0] sq_s;
    sq_s = lvl * lvl;
    if (lvl == max_v) begin
      return max_v;
    end else begin
      return calc_t'(sq_s >> bits);
    end
  endfunction
`endif

endpackage

// File: rtl/led_fade_channel.sv
// -----------------------------------------------------------------------------
// led_fade_channel
// One LED channel. It holds the brightness level ramp, the duty shadow register
// and the PWM compare.
//
// Optional build macro: LED_FADE_GAMMA_EN
//   When defined, the duty shadow loads a registered gamma(level) instead of
//   the level itself.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : registered on/off request for this LED
//   tick         : one-cycle fade step strobe shared by all channels
//   fade_en      : 1 = ramp on tick, 0 = snap to target
//   pwm_cnt      : shared free-running PWM counter
//   led_out      : registered PWM drive
//   busy         : level differs from target (combinational; top registers OR)
// -----------------------------------------------------------------------------
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                tick,
  input  logic                fade_en,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
  localparam calc_t               STEP_C   = calc_t'(FADE_STEP);
  localparam calc_t               MAX_C    = calc_t'(LVL_MAX);

  logic [PWM_BITS-1:0] level_r;
  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] target_s;
  logic [PWM_BITS-1:0] level_nxt_s;
  logic [PWM_BITS-1:0] duty_src_s;
  logic                led_out_r;

  assign target_s = req ? LVL_MAX : LVL_ZERO;

  // Next level: saturating ramp on tick in fade mode, direct follow otherwise
  always_comb begin
    level_nxt_s = level_r;
    if (fade_en) begin
      if (tick) begin
        if (req && (level_r != LVL_MAX)) begin
          level_nxt_s = PWM_BITS'(sat_add(calc_t'(level_r), STEP_C, MAX_C));
        end else if (!req && (level_r != LVL_ZERO)) begin
          level_nxt_s = PWM_BITS'(sat_sub(calc_t'(level_r), STEP_C));
        end else begin
          level_nxt_s = level_r;
        end
      end else begin
        level_nxt_s = level_r;
      end
    end else begin
      level_nxt_s = target_s;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [PWM_BITS-1:0] gamma_r;

  // Pipeline register on gamma(level) ahead of the duty shadow load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gamma_r <= LVL_ZERO;
    end else begin
      gamma_r <= PWM_BITS'(gamma(calc_t'(level_r), MAX_C, PWM_BITS));
    end
  end

  assign duty_src_s = gamma_r;
`else
  assign duty_src_s = level_r;
`endif

  // Level register, duty shadow loaded at the end of each PWM period, and PWM compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r   <= LVL_ZERO;
      duty_r    <= LVL_ZERO;
      led_out_r <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      // Loading only on the last count keeps each PWM period glitch-free.
      if (pwm_cnt == LVL_MAX) begin
        duty_r <= duty_src_s;
      end else begin
        duty_r <= duty_r;
      end
      // Full scale is forced on so there is no single dark cycle at pwm_cnt == MAX.
      led_out_r <= (duty_r == LVL_MAX) | (pwm_cnt < duty_r);
    end
  end

  assign led_out = led_out_r;
  assign busy    = (level_r != target_s);

endmodule

// File: rtl/led_fade_driver.sv
// -----------------------------------------------------------------------------
// led_fade_driver
// Turns per-LED on/off requests from the PIO out_port into PWM LED drive with
// linear fade-in and fade-out.
//
// Optional build macro: LED_FADE_GAMMA_EN (square-law duty map in each channel)
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   led_req  : [NUM_LEDS] on/off request per LED
//   fade_en  : 1 = ramp brightness, 0 = snap to target
//   led_out  : [NUM_LEDS] registered active-high PWM drive
//   busy     : registered, high while any channel level differs from its target
// -----------------------------------------------------------------------------
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int TICK_DIV  = 50000,
  parameter int FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_req,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [NUM_LEDS-1:0] req_q_r;
  logic [PRE_W-1:0]    prescaler_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                busy_r;
  logic                tick_s;
  logic [NUM_LEDS-1:0] ch_led_s;
  logic [NUM_LEDS-1:0] ch_busy_s;

  assign tick_s = (prescaler_r == PRE_LAST);

  // Input register, fade prescaler, free-running PWM counter and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q_r     <= {NUM_LEDS{1'b0}};
      prescaler_r <= {PRE_W{1'b0}};
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      req_q_r <= led_req;
      if (tick_s) begin
        prescaler_r <= {PRE_W{1'b0}};
      end else begin
        prescaler_r <= prescaler_r + PRE_W'(1);
      end
      // Natural wrap from MAX to 0 gives a 2^PWM_BITS period.
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      busy_r    <= |ch_busy_s;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_q_r[i]),
      .tick    (tick_s),
      .fade_en (fade_en),
      .pwm_cnt (pwm_cnt_r),
      .led_out (ch_led_s[i]),
      .busy    (ch_busy_s[i])
    );
  end

  assign led_out = ch_led_s;
  assign busy    = busy_r;

endmodule

// File: tb/tb_led_fade_driver.sv
// -----------------------------------------------------------------------------
// tb_led_fade_driver
// Scoreboard bench for led_fade_driver with TICK_DIV=4, FADE_STEP=4, PWM_BITS=8.
// The stimulus pushes hand-computed expectations into two queues. One queue
// holds point samples of led_out, busy or channel-0 level. The other holds
// per-PWM-window high-time counts. A separate monitor pops and compares them.
// The cycle index n counts rising edges since the last reset release. PWM
// window k covers the led_out samples after edges 256k-255 .. 256k.
// -----------------------------------------------------------------------------
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] led_req;
  logic       fade_en;
  logic [7:0] led_out;
  logic       busy;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS  (8),
    .PWM_BITS  (8),
    .TICK_DIV  (4),
    .FADE_STEP (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_req (led_req),
    .fade_en (fade_en),
    .led_out (led_out),
    .busy    (busy)
  );

  localparam int K_LED    = 0;
  localparam int K_BUSY   = 1;
  localparam int K_LEVEL0 = 2;

`ifdef LED_FADE_GAMMA_EN
  localparam int HI_252 = 248;  // (252*252)>>8
  localparam int HI_128 = 64;   // (128*128)>>8
`else
  localparam int HI_252 = 252;
  localparam int HI_128 = 128;
`endif

  typedef struct { string name; int kind; int exp; } inst_t;
  typedef struct { string name; int win; int ch; int exp; } per_t;

  inst_t inst_q[$];
  per_t  per_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n = 0;
  int    hi_cnt[8];

  // Rising edges since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n <= 0;
    else          n <= n + 1;
  end

  // Monitor: compares point samples and completed PWM windows
  initial begin : monitor
    inst_t e;
    per_t  p;
    int    act;
    int    w;
    for (int c = 0; c < 8; c++) hi_cnt[c] = 0;
    forever begin
      @(negedge clk);
      #1;
      while (inst_q.size() > 0) begin
        e = inst_q.pop_front();
        case (e.kind)
          K_LED:   act = int'(led_out);
          K_BUSY:  act = int'(busy);
          default: act = int'(dut.g_ch[0].u_chan.level_r);
        endcase
        checks++;
        if (act != e.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (n=%0d)", e.name, act, e.exp, n);
        end
      end
      if (!reset_n) begin
        for (int c = 0; c < 8; c++) hi_cnt[c] = 0;
      end else if (n > 0) begin
        for (int c = 0; c < 8; c++) if (led_out[c]) hi_cnt[c]++;
        if ((n % 256) == 0) begin
          w = n / 256;
          while (per_q.size() > 0 && per_q[0].win <= w) begin
            p = per_q.pop_front();
            act = (p.win == w) ? hi_cnt[p.ch] : -1;
            checks++;
            if (act != p.exp) begin
              errors++;
              $display("FAIL %s: high-time got %0d expected %0d (window %0d ch %0d)",
                       p.name, act, p.exp, p.win, p.ch);
            end
          end
          for (int c = 0; c < 8; c++) hi_cnt[c] = 0;
        end
      end
    end
  end

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (n < target) begin
      checks++;
      errors++;
      $display("FAIL wait_n: reached %0d expected %0d", n, target);
    end
  endtask

  task automatic expect_now(input string name, input int kind, input int exp);
    inst_t e;
    e.name = name; e.kind = kind; e.exp = exp;
    inst_q.push_back(e);
  endtask

  task automatic expect_win(input string name, input int win, input int ch, input int exp);
    per_t p;
    p.name = name; p.win = win; p.ch = ch; p.exp = exp;
    per_q.push_back(p);
  endtask

  // Stimulus
  initial begin
    reset_n = 1'b0;
    led_req = 8'h01;
    fade_en = 1'b1;
    repeat (3) @(negedge clk);

    // Run 1: fade-in of channel 0 from reset
    expect_win("fadein_w1_ch0", 1, 0, 0);
    expect_win("fadein_w2_ch0", 2, 0, HI_252);
    expect_win("fadein_w2_ch1", 2, 1, 0);
    expect_win("fadein_w3_ch0", 3, 0, 256);
    reset_n = 1'b1;
    wait_n(1);   expect_now("fadein_busy_n1",   K_BUSY,   0);
    wait_n(2);   expect_now("fadein_busy_n2",   K_BUSY,   1);
    wait_n(8);   expect_now("fadein_level_n8",  K_LEVEL0, 8);
    wait_n(100); expect_now("fadein_busy_n100", K_BUSY,   1);
    wait_n(252); expect_now("fadein_level_252", K_LEVEL0, 252);
    wait_n(256); expect_now("fadein_level_sat", K_LEVEL0, 255);
                 expect_now("fadein_busy_n256", K_BUSY,   1);
    wait_n(257); expect_now("fadein_busy_done", K_BUSY,   0);
    wait_n(800); led_req = 8'hFF;
    wait_n(899); expect_now("prereset_led",     K_LED,    8'h01);
                 expect_now("prereset_busy",    K_BUSY,   1);

    // Reset mid-fade clears everything at once
    wait_n(900);
    reset_n = 1'b0;
    expect_now("reset_led",   K_LED,    0);
    expect_now("reset_busy",  K_BUSY,   0);
    expect_now("reset_level", K_LEVEL0, 0);
    repeat (3) @(negedge clk);
    led_req = 8'h00;
    fade_en = 1'b1;

    // Run 2: reversal, duty shadow, snap, constant-on
    expect_win("shadow_w1_ch0", 1, 0, 0);
    expect_win("shadow_w2_ch0", 2, 0, 0);
    expect_win("shadow_w3_ch0", 3, 0, HI_128);
    expect_win("shadow_w3_ch1", 3, 1, 0);
    expect_win("shadow_w4_ch0", 4, 0, 256);
    expect_win("shadow_w5_ch0", 5, 0, 0);
    expect_win("shadow_w5_ch2", 5, 2, 0);
    for (int c = 0; c < 8; c++) expect_win("snap_w6", 6, c, ((8'hA5 >> c) & 1) ? 256 : 0);
    reset_n = 1'b1;
    wait_n(3);   expect_now("release_busy",  K_BUSY,   0);
                 expect_now("release_led",   K_LED,    0);
                 expect_now("release_level", K_LEVEL0, 0);
                 led_req = 8'h01;
    wait_n(104); expect_now("rev_level_peak", K_LEVEL0, 100);
    wait_n(105); led_req = 8'h00;
    wait_n(106); expect_now("rev_level_hold", K_LEVEL0, 100);
    wait_n(108); expect_now("rev_level_96",   K_LEVEL0, 96);
    wait_n(152); expect_now("rev_level_52",   K_LEVEL0, 52);
    wait_n(200); expect_now("rev_level_4",    K_LEVEL0, 4);
    wait_n(204); expect_now("rev_level_zero", K_LEVEL0, 0);
                 expect_now("rev_busy_204",   K_BUSY,   1);
    wait_n(205); expect_now("rev_busy_205",   K_BUSY,   0);
    wait_n(300); expect_now("rev_no_wrap",    K_LEVEL0, 0);
    wait_n(381); led_req = 8'h01;
    wait_n(508); expect_now("shadow_level_128", K_LEVEL0, 128);
    wait_n(640); expect_now("shadow_level_sat", K_LEVEL0, 255);
                 expect_now("shadow_busy_sat",  K_BUSY,   0);
    // Snap off at pwm_cnt == 50; the running period must keep its duty
    wait_n(818); fade_en = 1'b0; led_req = 8'h00;
    wait_n(820); expect_now("snapoff_busy_820", K_BUSY,   1);
    wait_n(821); expect_now("snapoff_busy_821", K_BUSY,   0);
                 expect_now("snapoff_level",    K_LEVEL0, 0);
    wait_n(900); expect_now("snapoff_led_held", K_LED,    8'h01);
    wait_n(1030); led_req = 8'hA5;
    wait_n(1032); expect_now("snap_busy_1032", K_BUSY, 1);
    wait_n(1033); expect_now("snap_busy_1033", K_BUSY, 0);
    wait_n(1300); expect_now("snap_led_1300",  K_LED,  8'hA5);
    wait_n(1400); expect_now("snap_led_1400",  K_LED,  8'hA5);
    wait_n(1536);
    repeat (2) @(negedge clk);

    // Every pushed expectation must have been consumed by the monitor
    if (inst_q.size() != 0 || per_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", inst_q.size() + per_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
